// File: rtl/score_pkg.sv
// Shared types, constants and the BCD increment helper for the score display block.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } score_state_t;

  localparam int         GLYPH_W    = 8;
  localparam int         GLYPH_H    = 8;
  localparam int         MAX_DIGITS = 8;
  localparam bcd_digit_t BCD_MAX    = 4'd9;

  // Adds one to the low ndig digits of v; returns {sum, carry_out} with the carry in bit 0
  // so callers can keep just the bits their digit count needs.
  function automatic logic [4*MAX_DIGITS:0] bcd_inc(input logic [4*MAX_DIGITS-1:0] v,
                                                    input int ndig);
    logic [4*MAX_DIGITS-1:0] r;
    logic                    c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < ndig) && c) begin
        if (v[4*i +: 4] == BCD_MAX) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {r, c};
  endfunction

endpackage

// File: rtl/score_font_rom.sv
// Combinational 10x8 digit glyph ROM; address is {digit, row}, data MSB is the leftmost pixel.
module score_font_rom
  import score_pkg::*;
(
  input  logic [6:0] addr,
  output logic [7:0] data
);

  bcd_digit_t  digit_s;
  logic [63:0] glyph_s;

  always_comb begin
    digit_s = addr[6:3];
    case (digit_s)
      4'd0:    glyph_s = 64'h3C666E7666663C00;
      4'd1:    glyph_s = 64'h1838181818187E00;
      4'd2:    glyph_s = 64'h3C66060C30607E00;
      4'd3:    glyph_s = 64'h3C66061C06663C00;
      4'd4:    glyph_s = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph_s = 64'h7E607C0606663C00;
      4'd6:    glyph_s = 64'h3C607C6666663C00;
      4'd7:    glyph_s = 64'h7E060C1830303000;
      4'd8:    glyph_s = 64'h3C66663C66663C00;
      4'd9:    glyph_s = 64'h3C66663E060C3800;
      default: glyph_s = 64'h0000000000000000;
    endcase
    // Row 0 sits in the top byte.
    data = glyph_s[{3'd7 - addr[2:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/score_display.sv
// N-digit BCD score accumulator with high score, frame-latched display copy and glyph pixel lookup.
// Optional macro SCORE_LZ_BLANK_EN enables leading-zero blanking of the rendered digits.
module score_display
  import score_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PTS_W    = 4,
  parameter int SATURATE = 0,
  parameter int GLYPH_W  = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_tick,
  input  logic                        add_valid,
  input  logic [PTS_W-1:0]            add_pts,
  output logic                        add_ready,
  input  logic                        clear_score,
  input  logic [$clog2(DIGITS*8)-1:0] X,
  input  logic [2:0]                  Y,
  output logic                        pixel,
  output logic [4*DIGITS-1:0]         score_bcd,
  output logic [4*DIGITS-1:0]         hiscore_bcd,
  output logic                        overflow
);

  localparam int XW  = $clog2(DIGITS*8);
  localparam int SW  = 4*DIGITS;
  localparam int MW  = 4*MAX_DIGITS;
  localparam int GSH = $clog2(GLYPH_W);
  localparam int SLW = (XW > GSH) ? XW - GSH : 1;

  logic [SW-1:0]    score_q, score_d, hiscore_q, hiscore_d, disp_q, disp_d;
  logic [PTS_W-1:0] pend_q, pend_d;
  logic             overflow_q, overflow_d, tick_q, tick_d, latch_q, latch_d;
  score_state_t     state_q, state_d;
  logic [MW-1:0]    score_ext_s;
  logic [SW:0]      inc_s;
  logic             accept_s;

  assign add_ready   = (state_q == IDLE) & ~clear_score;
  assign accept_s    = add_valid & add_ready;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;
  assign overflow    = overflow_q;

  always_comb begin
    score_ext_s         = '0;
    score_ext_s[SW-1:0] = score_q;
    inc_s               = (SW+1)'(bcd_inc(score_ext_s, DIGITS));
  end

  always_comb begin
    score_d    = score_q;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    if (clear_score) begin
      score_d    = '0;
      pend_d     = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s && (add_pts != '0)) begin
            pend_d  = add_pts;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
        COUNT: begin
          pend_d = pend_q - PTS_W'(1);
          // inc_s[0] is the carry out of the top digit: the score was all-9s.
          if (inc_s[0]) begin
            overflow_d = 1'b1;
            if (SATURATE != 0) begin
              score_d = score_q;
            end else begin
              score_d = inc_s[SW:1];
            end
          end else begin
            score_d = inc_s[SW:1];
          end
          if (pend_q == PTS_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = COUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if ((state_q == IDLE) && (score_q > hiscore_q)) begin
      hiscore_d = score_q;
    end else begin
      hiscore_d = hiscore_q;
    end
    tick_d  = frame_tick;
    latch_d = frame_tick & ~tick_q;
    if (latch_q) begin
      disp_d = score_q;
    end else begin
      disp_d = disp_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      score_q    <= '0;
      hiscore_q  <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      score_q    <= score_d;
      hiscore_q  <= hiscore_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      latch_q    <= latch_d;
    end
  end

  logic [SLW-1:0] slot_s;
  logic [GSH-1:0] col_s;
  bcd_digit_t     digit_s;
  logic [7:0]     row_s;
  logic           in_range_s, lit_s;
`ifdef SCORE_LZ_BLANK_EN
  logic [3:0]     didx_s, msd_s;
`endif

  score_font_rom u_font (
    .addr ({digit_s, Y}),
    .data (row_s)
  );

  always_comb begin
    slot_s     = SLW'(X >> GSH);
    col_s      = X[GSH-1:0];
    in_range_s = ({1'b0, X} < (XW+1)'(DIGITS*GLYPH_W));
    digit_s    = 4'd0;
`ifdef SCORE_LZ_BLANK_EN
    didx_s     = 4'd0;
    msd_s      = 4'd0;
`endif
    // Slot 0 is the leftmost cell and shows the most significant digit.
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = (int'(slot_s) == DIGITS-1-i) ? disp_q[4*i +: 4] : digit_s;
`ifdef SCORE_LZ_BLANK_EN
      didx_s  = (int'(slot_s) == DIGITS-1-i) ? 4'(i) : didx_s;
      msd_s   = (disp_q[4*i +: 4] != 4'd0) ? 4'(i) : msd_s;
`endif
    end
`ifdef SCORE_LZ_BLANK_EN
    lit_s = (didx_s <= msd_s);
`else
    lit_s = 1'b1;
`endif
    pixel = in_range_s & lit_s & row_s[3'd7 - col_s];
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: a wrapping and a saturating instance share the stimulus.
module tb_score_display;

  logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, add_valid = 1'b0, clear_score = 1'b0;
  logic [3:0] add_pts = 4'd0;
  logic [4:0] x_in = 5'd0;
  logic [2:0] y_in = 3'd0;
  logic        add_ready_w, pixel_w, overflow_w, add_ready_s, pixel_s, overflow_s;
  logic [11:0] score_w, hiscore_w, score_s, hiscore_s;

  score_display #(.DIGITS(3), .PTS_W(4), .SATURATE(0), .GLYPH_W(8)) dut (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick), .add_valid(add_valid),
    .add_pts(add_pts), .add_ready(add_ready_w), .clear_score(clear_score), .X(x_in), .Y(y_in),
    .pixel(pixel_w), .score_bcd(score_w), .hiscore_bcd(hiscore_w), .overflow(overflow_w)
  );

  score_display #(.DIGITS(3), .PTS_W(4), .SATURATE(1), .GLYPH_W(8)) dut_sat (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick), .add_valid(add_valid),
    .add_pts(add_pts), .add_ready(add_ready_s), .clear_score(clear_score), .X(x_in), .Y(y_in),
    .pixel(pixel_s), .score_bcd(score_s), .hiscore_bcd(hiscore_s), .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  typedef struct { int pts; int exp_w; int exp_s; logic ovf_w; logic ovf_s; } add_vec_t;
  typedef struct { int w; int s; logic ow; logic os; } exp_t;

  exp_t        sb_q[$];
  add_vec_t    tbl[9];
  logic [63:0] font_tb[10];
  int          total = 0, bad = 0;
  int          cur_w = 0, cur_s = 0, hi_w = 0, hi_s = 0;
  logic        ovf_w = 1'b0, ovf_s = 1'b0;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pixel of a displayed value d2 d1 d0 (d2 leftmost) at column xx, row yy.
  function automatic logic exp_pix(int d2, int d1, int d0, int xx, int yy);
    int          slot, dig;
    logic [63:0] g;
    logic [7:0]  row;
    if (xx >= 24) return 1'b0;
    slot = xx / 8;
    dig  = (slot == 0) ? d2 : ((slot == 1) ? d1 : d0);
`ifdef SCORE_LZ_BLANK_EN
    if ((2 - slot) > ((d2 != 0) ? 2 : ((d1 != 0) ? 1 : 0))) return 1'b0;
`endif
    g   = font_tb[dig];
    row = g[63 - 8*yy -: 8];
    return row[7 - xx % 8];
  endfunction

  task automatic scan(int d2, int d1, int d0, int yy);
    for (int xx = 0; xx < 32; xx++) begin
      x_in = 5'(xx);
      y_in = 3'(yy);
      #1;
      chk($sformatf("pix_w %0d%0d%0d x=%0d y=%0d", d2, d1, d0, xx, yy), 32'(pixel_w),
          32'(exp_pix(d2, d1, d0, xx, yy)));
      chk($sformatf("pix_s %0d%0d%0d x=%0d y=%0d", d2, d1, d0, xx, yy), 32'(pixel_s),
          32'(exp_pix(d2, d1, d0, xx, yy)));
    end
  endtask

  task automatic do_add(int pts, int ew, int es, logic ow, logic os);
    exp_t e;
    int   cnt;
    int   hw_old, hs_old;
    hw_old = hi_w;
    hs_old = hi_s;
    @(negedge clk);
    chk("ready_before_add", 32'(add_ready_w), 32'd1);
    add_valid = 1'b1;
    add_pts   = 4'(pts);
    e.w = ew; e.s = es; e.ow = ow; e.os = os;
    sb_q.push_back(e);
    @(negedge clk);
    add_valid = 1'b0;
    add_pts   = 4'd0;
    cnt = 0;
    while (!add_ready_w && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles pts=%0d", pts), 32'(cnt), 32'(pts));
    chk("ready_sat", 32'(add_ready_s), 32'd1);
    e = sb_q.pop_front();
    chk($sformatf("score_wrap pts=%0d", pts), 32'(score_w), 32'(to_bcd(e.w)));
    chk($sformatf("score_sat pts=%0d", pts), 32'(score_s), 32'(to_bcd(e.s)));
    chk("ovf_wrap", 32'(overflow_w), 32'(e.ow));
    chk("ovf_sat", 32'(overflow_s), 32'(e.os));
    chk("hiscore_hold_w", 32'(hiscore_w), 32'(to_bcd(hw_old)));
    chk("hiscore_hold_s", 32'(hiscore_s), 32'(to_bcd(hs_old)));
    cur_w = ew; cur_s = es; ovf_w = ow; ovf_s = os;
    if (ew > hi_w) hi_w = ew;
    if (es > hi_s) hi_s = es;
    @(negedge clk);
    chk("hiscore_upd_w", 32'(hiscore_w), 32'(to_bcd(hi_w)));
    chk("hiscore_upd_s", 32'(hiscore_s), 32'(to_bcd(hi_s)));
  endtask

  task automatic model_add(int pts);
    int sw, ss;
    sw = cur_w + pts;
    ss = cur_s + pts;
    do_add(pts, sw % 1000, (ss > 999) ? 999 : ss, ovf_w | (sw > 999), ovf_s | (ss > 999));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    cur_w = 0; cur_s = 0; ovf_w = 1'b0; ovf_s = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    font_tb[0] = 64'h3C666E7666663C00; font_tb[1] = 64'h1838181818187E00;
    font_tb[2] = 64'h3C66060C30607E00; font_tb[3] = 64'h3C66061C06663C00;
    font_tb[4] = 64'h0C1C3C6C7E0C0C00; font_tb[5] = 64'h7E607C0606663C00;
    font_tb[6] = 64'h3C607C6666663C00; font_tb[7] = 64'h7E060C1830303000;
    font_tb[8] = 64'h3C66663C66663C00; font_tb[9] = 64'h3C66663E060C3800;
    tbl[0] = '{0, 5, 5, 1'b0, 1'b0};
    tbl[1] = '{15, 20, 20, 1'b0, 1'b0};
    tbl[2] = '{15, 35, 35, 1'b0, 1'b0};
    tbl[3] = '{15, 50, 50, 1'b0, 1'b0};
    tbl[4] = '{15, 65, 65, 1'b0, 1'b0};
    tbl[5] = '{15, 80, 80, 1'b0, 1'b0};
    tbl[6] = '{15, 95, 95, 1'b0, 1'b0};
    tbl[7] = '{4, 99, 99, 1'b0, 1'b0};
    tbl[8] = '{3, 102, 102, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(add_ready_w), 32'd1);
    chk("rst_score", 32'(score_w), 32'd0);
    chk("rst_hiscore", 32'(hiscore_w), 32'd0);
    chk("rst_ovf", 32'(overflow_w), 32'd0);
    chk("rst_score_sat", 32'(score_s), 32'd0);

    model_add(5);
    for (int i = 0; i < 9; i++) begin
      do_add(tbl[i].pts, tbl[i].exp_w, tbl[i].exp_s, tbl[i].ovf_w, tbl[i].ovf_s);
    end
    while (cur_w < 985) model_add(15);
    model_add(999 - cur_w);
    model_add(2);
    model_add(1);

    // Clear keeps the high score and drops overflow.
    pulse_clear();
    chk("clr_score_w", 32'(score_w), 32'd0);
    chk("clr_score_s", 32'(score_s), 32'd0);
    chk("clr_ovf_w", 32'(overflow_w), 32'd0);
    chk("clr_ovf_s", 32'(overflow_s), 32'd0);
    chk("clr_hi_w", 32'(hiscore_w), 32'(to_bcd(999)));
    chk("clr_hi_s", 32'(hiscore_s), 32'(to_bcd(999)));

    // Clear two cycles into an add of 9, with a competing request held alongside it.
    @(negedge clk);
    add_valid = 1'b1;
    add_pts   = 4'd9;
    @(negedge clk);
    add_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_count_score", 32'(score_w), 32'(to_bcd(2)));
    clear_score = 1'b1;
    add_valid   = 1'b1;
    add_pts     = 4'd3;
    #1;
    chk("clr_ready_count", 32'(add_ready_w), 32'd0);
    @(negedge clk);
    chk("clr_prio_score", 32'(score_w), 32'd0);
    chk("clr_prio_ready", 32'(add_ready_w), 32'd0);
    clear_score = 1'b0;
    add_valid   = 1'b0;
    add_pts     = 4'd0;
    @(negedge clk);
    chk("clr_idle_ready", 32'(add_ready_w), 32'd1);
    @(negedge clk);
    chk("clr_no_accept", 32'(score_w), 32'd0);
    chk("clr_hi_kept", 32'(hiscore_w), 32'(to_bcd(999)));

    // Display still holds the reset copy while the score climbs to 047.
    model_add(15); model_add(15); model_add(15); model_add(2);
    scan(0, 0, 0, 0);
    @(negedge clk);
    x_in = 5'd17;
    y_in = 3'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    chk("latch_not_yet", 32'(pixel_w), 32'(exp_pix(0, 0, 0, 17, 0)));
    @(negedge clk);
    chk("latch_one_cycle", 32'(pixel_w), 32'(exp_pix(0, 4, 7, 17, 0)));
    frame_tick = 1'b0;
    @(negedge clk);
    scan(0, 4, 7, 0);
    scan(0, 4, 7, 3);
    model_add(1);
    scan(0, 4, 7, 0);

    pulse_clear();
    pulse_frame();
    scan(0, 0, 0, 0);
    model_add(7);
    pulse_frame();
    scan(0, 0, 7, 0);
    scan(0, 0, 7, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
